// File: rtl/prog_exec_engine.sv
// prog_exec_engine: runs a loaded program of move/arith/output/assert ops against a small local
// memory, streaming OUT values through a valid/ready FIFO and reporting finished/success.
module prog_exec_engine #(
   parameter int WIDTH     = 12,
   parameter int NLOCAL    = 16,
   parameter int NPROG     = 32,
   parameter int NOUT      = 4,
   parameter int MAX_STEPS = 1000,
   localparam int LAW = $clog2(NLOCAL),
   localparam int PAW = $clog2(NPROG),
   localparam int IW  = 3 + LAW + 2*WIDTH + 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load_valid,
   input  logic [PAW-1:0]   load_addr,
   input  logic [IW-1:0]    load_data,
   input  logic             start,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic             busy,
   output logic             finished,
   output logic             success,
   output logic [15:0]      steps
);
   localparam int FAW = $clog2(NOUT);
   localparam logic [2:0] OP_HALT = 3'd0, OP_MOV = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd3,
                          OP_OUT = 3'd4, OP_AEQ = 3'd5;
   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FETCH, S_EXEC, S_STALL, S_DONE} state_t;
   state_t state, state_n;
   logic [IW-1:0] prog [NPROG];
   logic [WIDTH-1:0] lmem [NLOCAL];
   logic [WIDTH-1:0] fmem [NOUT];
   logic [IW-1:0] ir;
   logic [PAW-1:0] ip;
   logic [LAW-1:0] clr_cnt, dst;
   logic [FAW-1:0] wp, rp;
   logic [FAW:0] cnt;
   logic [2:0] op;
   logic [WIDTH-1:0] fa, fb, va, vb, lval;
   logic [15:0] steps_inc;
   logic succ_r, exec, full, pop, push, stall, halt, afail, done, go, lwr;
   assign op        = ir[IW-1 -: 3];
   assign dst       = ir[2+2*WIDTH +: LAW];
   assign fa        = ir[2+WIDTH +: WIDTH];
   assign fb        = ir[2 +: WIDTH];
   assign va        = ir[1] ? fa : lmem[fa[LAW-1:0]];
   assign vb        = ir[0] ? fb : lmem[fb[LAW-1:0]];
   assign exec      = state == S_EXEC;
   assign full      = cnt == (FAW+1)'(NOUT);
   assign out_valid = cnt != '0;
   assign out_data  = out_valid ? fmem[rp] : '0;
   assign pop       = out_valid && out_ready;
   // a pop in the same cycle frees a slot, so a full FIFO only stalls without one
   assign stall     = exec && op == OP_OUT && full && !pop;
   assign push      = exec && op == OP_OUT && !stall;
   assign lwr       = exec && (op == OP_MOV || op == OP_ADD || op == OP_SUB);
   assign lval      = op == OP_MOV ? va : op == OP_ADD ? va + vb : va - vb;
   assign steps_inc = steps == 16'hFFFF ? steps : steps + 16'd1;
   assign halt      = op == OP_HALT;
   assign afail     = op == OP_AEQ && va != vb;
   assign done      = halt || afail || ip == PAW'(NPROG-1) || {16'd0, steps_inc} >= 32'(MAX_STEPS);
   assign go        = start && (state == S_IDLE || state == S_DONE);
   // gated by reset so busy reads 0 while reset is held, then 1 through the clear
   assign busy      = reset && (state == S_CLEAR || state == S_FETCH || state == S_EXEC || state == S_STALL);
   assign finished  = state == S_DONE;
   assign success   = succ_r;
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:  state_n = start ? S_FETCH : S_IDLE;
         S_CLEAR: state_n = clr_cnt == LAW'(NLOCAL-1) ? S_IDLE : S_CLEAR;
         S_FETCH: state_n = S_EXEC;
         S_EXEC:  state_n = stall ? S_STALL : done ? S_DONE : S_FETCH;
         S_STALL: state_n = full ? S_STALL : S_EXEC;
         S_DONE:  state_n = start ? S_FETCH : S_DONE;
         default: state_n = S_IDLE;
      endcase
   end
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= S_CLEAR;
         ip      <= '0;
         steps   <= '0;
         succ_r  <= 1'b0;
         clr_cnt <= '0;
         wp      <= '0;
         rp      <= '0;
         cnt     <= '0;
      end else begin
         state <= state_n;
         if (state == S_CLEAR) clr_cnt <= clr_cnt + LAW'(1);
         if (go) begin
            ip     <= '0;
            steps  <= '0;
            succ_r <= 1'b0;
         end
         if (exec && !stall) begin
            ip     <= ip + PAW'(1);
            steps  <= steps_inc;
            succ_r <= halt;
         end
         if (push) wp <= wp + FAW'(1);
         if (pop) rp <= rp + FAW'(1);
         cnt <= cnt + (FAW+1)'(push) - (FAW+1)'(pop);
      end
   end
   always_ff @(posedge clock) begin
      if (load_valid && state == S_IDLE) prog[load_addr] <= load_data;
      if (state == S_FETCH) ir <= prog[ip];
      if (state == S_CLEAR) lmem[clr_cnt] <= '0;
      else if (lwr) lmem[dst] <= lval;
      if (push) fmem[wp] <= va;
   end
endmodule

// File: tb/tb_prog_exec_engine.sv
// tb_prog_exec_engine: directed and random programs run on two engines (default and short step
// limit), checked against a sequential interpreter of the instruction set.
`timescale 1ns/1ps
module tb_prog_exec_engine;
   localparam int WIDTH = 12, NLOCAL = 16, LAW = 4, NPROG = 32, IW = 3 + LAW + 2*WIDTH + 2, TMO = 10;
   logic clock = 1'b0, reset = 1'b1, load_valid = 1'b0, start = 1'b0, out_ready = 1'b0;
   logic [4:0] load_addr = '0;
   logic [IW-1:0] load_data = '0;
   logic out_valid, busy, finished, success, out_valid_t, busy_t, finished_t, success_t;
   logic [WIDTH-1:0] out_data, out_data_t;
   logic [15:0] steps, steps_t;
   int n_chk = 0, n_fail = 0;
   logic [IW-1:0] prog_m [NPROG];
   logic [IW-1:0] new_p [NPROG];
   logic [WIDTH-1:0] mm [2][NLOCAL];
   int exp_steps [2];
   bit exp_ok [2];
   logic [WIDTH-1:0] exp_q [$];
   logic [WIDTH-1:0] got_q [$];

   prog_exec_engine dut (
      .clock(clock), .reset(reset), .load_valid(load_valid), .load_addr(load_addr),
      .load_data(load_data), .start(start), .out_valid(out_valid), .out_data(out_data),
      .out_ready(out_ready), .busy(busy), .finished(finished), .success(success), .steps(steps));
   prog_exec_engine #(.MAX_STEPS(TMO)) dut_t (
      .clock(clock), .reset(reset), .load_valid(load_valid), .load_addr(load_addr),
      .load_data(load_data), .start(start), .out_valid(out_valid_t), .out_data(out_data_t),
      .out_ready(out_ready), .busy(busy_t), .finished(finished_t), .success(success_t), .steps(steps_t));

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   function automatic logic [IW-1:0] ins(input int op, input int dst, input int a, input bit ai,
                                         input int b, input bit bi);
      return {3'(op), LAW'(dst), WIDTH'(a), WIDTH'(b), ai, bi};
   endfunction

   // Interprets prog_m one instruction at a time on local memory image k.
   task automatic model(input int k, input int lim);
      int ip, st;
      bit fin;
      logic [IW-1:0] w;
      logic [2:0] op;
      logic [WIDTH-1:0] fa, fb, a, b;
      ip = 0; st = 0; fin = 0;
      if (k == 0) exp_q.delete();
      while (!fin) begin
         w  = prog_m[ip];
         op = w[IW-1 -: 3];
         fa = w[2+WIDTH +: WIDTH];
         fb = w[2 +: WIDTH];
         a  = w[1] ? fa : mm[k][fa[LAW-1:0]];
         b  = w[0] ? fb : mm[k][fb[LAW-1:0]];
         st++;
         case (op)
            3'd1: mm[k][w[2+2*WIDTH +: LAW]] = a;
            3'd2: mm[k][w[2+2*WIDTH +: LAW]] = a + b;
            3'd3: mm[k][w[2+2*WIDTH +: LAW]] = a - b;
            3'd4: if (k == 0) exp_q.push_back(a);
            default: ;
         endcase
         exp_ok[k] = op == 3'd0;
         fin = op == 3'd0 || (op == 3'd5 && a != b) || ip == NPROG-1 || st >= lim;
         ip++;
      end
      exp_steps[k] = st;
   endtask

   task automatic do_reset();
      reset = 1'b0; load_valid = 1'b0; start = 1'b0; out_ready = 1'b0;
      #1;
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_data", 32'(out_data), 0);
      chk("rst_finished", 32'(finished), 0);
      chk("rst_success", 32'(success), 0);
      chk("rst_steps", 32'(steps), 0);
      chk("rst_busy", 32'(busy), 0);
      @(negedge clock);
      reset = 1'b1;
      foreach (mm[k, i]) mm[k][i] = '0;
      @(negedge clock);
      chk("clr_busy", 32'(busy), 1);
      for (int i = 0; i < 40 && (busy || busy_t); i++) @(negedge clock);
      chk("clr_done", 32'(busy), 0);
   endtask

   // Loads new_p with start raised on the last word; without a reset the engine sits in
   // DONE, so the load is ignored and the previous program is rerun.
   task automatic prep(input bit rst);
      if (rst) do_reset();
      for (int i = 0; i < NPROG; i++) begin
         load_valid = 1'b1; load_addr = 5'(i); load_data = new_p[i]; start = (i == NPROG-1);
         @(negedge clock);
      end
      load_valid = 1'b0; start = 1'b0;
      if (rst) prog_m = new_p;
      model(0, 1000);
      model(1, TMO);
      got_q.delete();
   endtask

   task automatic drain_verify(input string tag, input int pct);
      int cyc;
      for (cyc = 0; cyc < 4000; cyc++) begin
         if (finished && finished_t && !out_valid && !out_valid_t) break;
         out_ready = $urandom_range(99) < pct;
         if (out_valid && out_ready) got_q.push_back(out_data);
         @(negedge clock);
      end
      out_ready = 1'b0;
      chk({tag, "_bound"}, 32'(cyc < 4000), 1);
      chk({tag, "_finished"}, 32'(finished), 1);
      chk({tag, "_steps"}, 32'(steps), 32'(exp_steps[0]));
      chk({tag, "_success"}, 32'(success), 32'(exp_ok[0]));
      chk({tag, "_t_steps"}, 32'(steps_t), 32'(exp_steps[1]));
      chk({tag, "_t_success"}, 32'(success_t), 32'(exp_ok[1]));
      chk({tag, "_nout"}, 32'(got_q.size()), 32'(exp_q.size()));
      foreach (exp_q[i]) if (i < got_q.size()) chk({tag, "_out"}, 32'(got_q[i]), 32'(exp_q[i]));
   endtask

   task automatic clr_p(input int op);
      foreach (new_p[i]) new_p[i] = ins(op, 0, 0, 0, 0, 0);
   endtask

   task automatic gen();
      int hpos, op, dst, a, b;
      bit ai, bi;
      hpos = $urandom_range(NPROG + 8);
      for (int i = 0; i < NPROG; i++) begin
         op = $urandom_range(7, 1); dst = $urandom_range(15);
         a = $urandom_range(4095); b = $urandom_range(4095);
         ai = 1'($urandom_range(1)); bi = 1'($urandom_range(1));
         if (op == 5 && $urandom_range(1) == 1) begin b = a; bi = ai; end
         if (i == hpos) op = 0;
         new_p[i] = ins(op, dst, a, ai, b, bi);
      end
   endtask

   initial begin
      #2;
      do_reset();
      clr_p(0);
      new_p[0] = ins(3, 0, 4, 1, 2, 1);
      new_p[1] = ins(4, 0, 0, 0, 0, 1);
      new_p[2] = ins(5, 0, 0, 0, 2, 1);
      prep(1);
      drain_verify("s1", 100);
      chk("s1_nconst", 32'(got_q.size()), 1);
      if (got_q.size() > 0) chk("s1_val", 32'(got_q[0]), 2);
      chk("s1_stepsc", 32'(steps), 4);
      chk("s1_okc", 32'(success), 1);
      clr_p(0);
      new_p[0] = ins(3, 1, 2, 1, 4, 1);
      new_p[1] = ins(4, 0, 1, 0, 0, 0);
      new_p[2] = ins(2, 2, 4095, 1, 3, 1);
      new_p[3] = ins(4, 0, 2, 0, 0, 0);
      prep(1);
      drain_verify("wrap", 70);
      if (got_q.size() == 2) begin
         chk("wrap_sub", 32'(got_q[0]), 4094);
         chk("wrap_add", 32'(got_q[1]), 2);
      end
      clr_p(0);
      for (int i = 0; i < 6; i++) new_p[i] = ins(4, 0, i + 1, 1, 0, 0);
      prep(1);
      repeat (40) @(negedge clock);
      chk("stall_steps", 32'(steps), 4);
      chk("stall_busy", 32'(busy), 1);
      chk("stall_fin", 32'(finished), 0);
      drain_verify("stall", 100);
      if (got_q.size() == 6) foreach (got_q[i]) chk("stall_order", 32'(got_q[i]), 32'(i + 1));
      clr_p(0);
      new_p[0] = ins(5, 0, 3, 1, 5, 1);
      new_p[1] = ins(4, 0, 7, 1, 0, 0);
      prep(1);
      drain_verify("afail", 100);
      chk("afail_steps", 32'(steps), 1);
      chk("afail_ok", 32'(success), 0);
      chk("afail_nout", 32'(got_q.size()), 0);
      clr_p(6);
      prep(1);
      drain_verify("nop", 100);
      chk("nop_steps", 32'(steps), 32);
      chk("nop_t_steps", 32'(steps_t), TMO);
      chk("nop_t_ok", 32'(success_t), 0);
      clr_p(0);
      for (int i = 0; i < 6; i++) new_p[i] = ins(4, 0, i + 1, 1, 0, 0);
      prep(1);
      repeat (40) @(negedge clock);
      do_reset();
      clr_p(0);
      new_p[0] = ins(3, 0, 4, 1, 2, 1);
      new_p[1] = ins(4, 0, 0, 0, 0, 1);
      new_p[2] = ins(5, 0, 0, 0, 2, 1);
      prep(1);
      drain_verify("rerun", 100);
      chk("rerun_ok", 32'(success), 1);
      for (int r = 0; r < 30; r++) begin
         gen();
         prep($urandom_range(2) != 0);
         drain_verify("rand", 30 + int'($urandom_range(70)));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
